// File: rtl/pong_rc_adc.sv
// RC-timing paddle ADC: discharge, time the charge per channel, scale to a position. Compile with RC_ADC_FILTER_EN to average each new reading with the old one.
// Latency: one sample per DISCHARGE+CHARGE+UPDATE pass; sample_valid pulses the cycle after UPDATE. There is no backpressure; en=0 parks the FSM in DISCHARGE.
module pong_rc_adc #(
    parameter int DISCHARGE_CYCLES = 12000,
    parameter int TIMEOUT          = 65535,
    parameter int SHIFT            = 6,
    parameter int POS_MAX          = 479
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       cmp_ply1,
    input  logic       cmp_ply2,
    output logic       dis_ply1,
    output logic       dis_ply2,
    output logic [9:0] pos_ply1,
    output logic [9:0] pos_ply2,
    output logic       sample_valid
);

    localparam logic [15:0] LP_DIS_LAST = 16'(DISCHARGE_CYCLES - 1);
    localparam logic [15:0] LP_TIMEOUT  = 16'(TIMEOUT);
    localparam logic [15:0] LP_POS_MAX  = 16'(POS_MAX);
    localparam logic [9:0]  LP_POS_RST  = 10'd240;

    typedef enum logic [1:0] {DISCHARGE, CHARGE, UPDATE} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_done1, r_done2, w_done1_nxt, w_done2_nxt;
    logic [15:0] r_lat1, r_lat2, w_lat1_nxt, w_lat2_nxt;
    logic        r_meta1, r_meta2, r_sync1, r_sync2;
    logic        r_dis, r_sv;
    logic [9:0]  r_pos1, r_pos2;
    logic [15:0] w_shift1, w_shift2;
    logic [9:0]  w_new1, w_new2, w_upd1, w_upd2;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done1_nxt = r_done1;
        w_done2_nxt = r_done2;
        w_lat1_nxt  = r_lat1;
        w_lat2_nxt  = r_lat2;
        case (r_state)
            DISCHARGE: begin
                if (r_cnt >= LP_DIS_LAST) begin
                    if (en) begin
                        w_state_nxt = CHARGE;
                        w_cnt_nxt   = 16'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            CHARGE: begin
                if (r_sync1 && !r_done1) begin
                    w_lat1_nxt  = r_cnt;
                    w_done1_nxt = 1'b1;
                end
                if (r_sync2 && !r_done2) begin
                    w_lat2_nxt  = r_cnt;
                    w_done2_nxt = 1'b1;
                end
                if (w_done1_nxt && w_done2_nxt) begin
                    w_state_nxt = UPDATE;
                    w_cnt_nxt   = 16'd0;
                end else if (r_cnt == LP_TIMEOUT) begin
                    // A channel that never tripped reads as full-scale.
                    if (!w_done1_nxt) w_lat1_nxt = LP_TIMEOUT;
                    if (!w_done2_nxt) w_lat2_nxt = LP_TIMEOUT;
                    w_done1_nxt = 1'b1;
                    w_done2_nxt = 1'b1;
                    w_state_nxt = UPDATE;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            UPDATE: begin
                w_state_nxt = DISCHARGE;
                w_cnt_nxt   = 16'd0;
                w_done1_nxt = 1'b0;
                w_done2_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = DISCHARGE;
                w_cnt_nxt   = 16'd0;
                w_done1_nxt = 1'b0;
                w_done2_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_shift1 = r_lat1 >> SHIFT;
        w_shift2 = r_lat2 >> SHIFT;
        w_new1   = 10'((w_shift1 > LP_POS_MAX) ? LP_POS_MAX : w_shift1);
        w_new2   = 10'((w_shift2 > LP_POS_MAX) ? LP_POS_MAX : w_shift2);
`ifdef RC_ADC_FILTER_EN
        w_upd1   = 10'(({1'b0, r_pos1} + {1'b0, w_new1}) >> 1);
        w_upd2   = 10'(({1'b0, r_pos2} + {1'b0, w_new2}) >> 1);
`else
        w_upd1   = w_new1;
        w_upd2   = w_new2;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta1 <= 1'b0;
            r_meta2 <= 1'b0;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= DISCHARGE;
            r_cnt   <= 16'd0;
            r_done1 <= 1'b0;
            r_done2 <= 1'b0;
            r_lat1  <= 16'd0;
            r_lat2  <= 16'd0;
            r_dis   <= 1'b1;
            r_sv    <= 1'b0;
            r_pos1  <= LP_POS_RST;
            r_pos2  <= LP_POS_RST;
        end else begin
            r_meta1 <= cmp_ply1;
            r_meta2 <= cmp_ply2;
            r_sync1 <= r_meta1;
            r_sync2 <= r_meta2;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done1 <= w_done1_nxt;
            r_done2 <= w_done2_nxt;
            r_lat1  <= w_lat1_nxt;
            r_lat2  <= w_lat2_nxt;
            // Registered from next-state so the switch drive never glitches.
            r_dis   <= (w_state_nxt == DISCHARGE);
            r_sv    <= (r_state == UPDATE);
            if (r_state == UPDATE) begin
                r_pos1 <= w_upd1;
                r_pos2 <= w_upd2;
            end
        end
    end

    assign dis_ply1     = r_dis;
    assign dis_ply2     = r_dis;
    assign pos_ply1     = r_pos1;
    assign pos_ply2     = r_pos2;
    assign sample_valid = r_sv;

endmodule

// File: tb/tb_pong_rc_adc.sv
// Bench for pong_rc_adc: two instances (SHIFT=2 and SHIFT=0) share stimulus; expected positions are queued per sample.
module tb_pong_rc_adc;

    localparam int DC   = 4;
    localparam int TO   = 1000;
    localparam int PMAX = 479;

    logic       clk = 1'b0;
    logic       rst_n, en, cmp1, cmp2;
    logic       dis_a1, dis_a2, dis_b1, dis_b2, sv_a, sv_b;
    logic [9:0] pos_a1, pos_a2, pos_b1, pos_b2;

    always #5 clk = ~clk;

    pong_rc_adc #(.DISCHARGE_CYCLES(DC), .TIMEOUT(TO), .SHIFT(2), .POS_MAX(PMAX)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .cmp_ply1(cmp1), .cmp_ply2(cmp2),
        .dis_ply1(dis_a1), .dis_ply2(dis_a2), .pos_ply1(pos_a1), .pos_ply2(pos_a2),
        .sample_valid(sv_a));

    pong_rc_adc #(.DISCHARGE_CYCLES(DC), .TIMEOUT(TO), .SHIFT(0), .POS_MAX(PMAX)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .cmp_ply1(cmp1), .cmp_ply2(cmp2),
        .dis_ply1(dis_b1), .dis_ply2(dis_b2), .pos_ply1(pos_b1), .pos_ply2(pos_b2),
        .sample_valid(sv_b));

    typedef struct {
        int a1;
        int a2;
        int b1;
        int b2;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_a1 = 240, m_a2 = 240, m_b1 = 240, m_b2 = 240;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int new_pos(input int t, input int sh);
        int v;
        v = t >> sh;
        if (v > PMAX) v = PMAX;
        return v;
    endfunction

    function automatic int filt(input int old, input int nw);
`ifdef RC_ADC_FILTER_EN
        return (old + nw) >> 1;
`else
        return nw + 0 * old;
`endif
    endfunction

    task automatic push_exp(input int t1, input int t2);
        exp_t e;
        int   l1, l2;
        l1   = (t1 < 0) ? TO : t1;
        l2   = (t2 < 0) ? TO : t2;
        m_a1 = filt(m_a1, new_pos(l1, 2));
        m_a2 = filt(m_a2, new_pos(l2, 2));
        m_b1 = filt(m_b1, new_pos(l1, 0));
        m_b2 = filt(m_b2, new_pos(l2, 0));
        e.a1 = m_a1; e.a2 = m_a2; e.b1 = m_b1; e.b2 = m_b2;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outs(input string pfx);
        chk({pfx, "_dis1"}, dis_a1, 1);
        chk({pfx, "_dis2"}, dis_a2, 1);
        chk({pfx, "_disb"}, dis_b1 & dis_b2, 1);
        chk({pfx, "_pos1"}, pos_a1, 240);
        chk({pfx, "_pos2"}, pos_a2, 240);
        chk({pfx, "_sv"}, sv_a | sv_b, 0);
    endtask

    // t<0: comparator never trips; t==0: held high before CHARGE begins.
    task automatic run_sample(input int t1, input int t2, input bit chk_dis,
                              input int en_drop_k, input int abort_k);
        int   dcnt, k, tmax;
        bit   got_sv;
        exp_t e;
        push_exp(t1, t2);
        tmax = (t1 < 0 || t2 < 0) ? TO : ((t1 > t2) ? t1 : t2);
        if (t1 == 0) cmp1 = 1'b1;
        if (t2 == 0) cmp2 = 1'b1;
        dcnt = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (i == 0) chk("sv_pulse", sv_a, 0);
            if (dis_a1 === 1'b0) break;
            if (sv_a !== 1'b0) chk("sv_spurious", sv_a, 0);
            dcnt++;
        end
        chk("chg_start", dis_a1, 0);
        if (chk_dis) chk("dis_len", dcnt, DC);
        k      = 0;
        got_sv = 1'b0;
        while (k < 1200) begin
            if (t1 >= 2 && k == t1 - 2) cmp1 = 1'b1;
            if (t2 >= 2 && k == t2 - 2) cmp2 = 1'b1;
            if (k == en_drop_k) en = 1'b0;
            if (k == abort_k) begin
                #2 rst_n = 1'b0;
                #1;
                m_a1 = 240; m_a2 = 240; m_b1 = 240; m_b2 = 240;
                void'(exp_q.pop_back());
                check_reset_outs("abort");
                cmp1 = 1'b0;
                cmp2 = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("abort_sv", sv_a, 0);
                end
                rst_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
            k++;
            if (sv_a === 1'b1) begin
                got_sv = 1'b1;
                break;
            end
        end
        chk("sv_seen", got_sv, 1);
        e = exp_q.pop_front();
        if (got_sv) begin
            chk("chg_len", k, tmax + 2);
            chk("sv_b", sv_b, 1);
            chk("pos_a1", pos_a1, e.a1);
            chk("pos_a2", pos_a2, e.a2);
            chk("pos_b1", pos_b1, e.b1);
            chk("pos_b2", pos_b2, e.b2);
        end
        cmp1 = 1'b0;
        cmp2 = 1'b0;
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        en    = 1'b1;
        cmp1  = 1'b0;
        cmp2  = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check_reset_outs("rst");
        end
        rst_n = 1'b1;

        run_sample(400, 200, 1'b1, -1, -1);
        run_sample(40, -1, 1'b1, -1, -1);
        run_sample(600, 0, 1'b1, -1, -1);
        run_sample(0, 0, 1'b1, -1, -1);
        run_sample(100, 100, 1'b1, 50, -1);

        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (dis_a1 !== 1'b1 || sv_a !== 1'b0) bad++;
        end
        chk("park", bad, 0);
        en = 1'b1;

        run_sample(-1, -1, 1'b0, -1, 300);
        run_sample(8, 1000, 1'b1, -1, -1);
        run_sample(3, 2, 1'b1, -1, -1);

        chk("q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
